timer_regfile: RTL and testbench

Parametrised register file for the traffic-light datapath, holding the per-phase countdown values. It provides one write port, two registered read ports with valid strobes, and a decrement port that counts a selected register down and saturates at zero. A per-register zero-flag vector is exposed to the controller FSM. The block adds synchronous reset and same-cycle write/decrement forwarding to the reads.

---
 rtl/timer_regfile_if.sv | 32 +++
 rtl/timer_regfile.sv | 61 ++++++
 tb/tb_timer_regfile.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/timer_regfile_if.sv
// Bus bundle for timer_regfile: write, decrement and dual read ports plus zero flags.
// Read strobes: validA/validB are high for exactly the one cycle after an edge that sampled REA/REB high.
interface timer_regfile_if #(
    parameter int data_width = 8,
    parameter int reg_width  = 2,
    parameter int reg_num    = 4
);
    logic [data_width-1:0] data_in;
    logic [reg_width-1:0]  WA;
    logic                  WEn;
    logic                  DEC;
    logic [reg_width-1:0]  DA;
    logic                  REA;
    logic                  REB;
    logic [reg_width-1:0]  RAA;
    logic [reg_width-1:0]  RAB;
    logic [data_width-1:0] outA;
    logic [data_width-1:0] outB;
    logic                  validA;
    logic                  validB;
    logic [reg_num-1:0]    ZERO;

    modport master (
        output data_in, WA, WEn, DEC, DA, REA, REB, RAA, RAB,
        input  outA, outB, validA, validB, ZERO
    );

    modport slave (
        input  data_in, WA, WEn, DEC, DA, REA, REB, RAA, RAB,
        output outA, outB, validA, validB, ZERO
    );
endinterface

// File: rtl/timer_regfile.sv
// Per-phase countdown register file: one write port, one saturating decrement port,
// two registered read ports that see this edge's write/decrement, and a zero-flag vector.
module timer_regfile #(
    parameter int data_width = 8,
    parameter int reg_width  = 2,
    parameter int reg_num    = 4
) (
    input logic             CLK,
    input logic             RST,
    timer_regfile_if.slave  bus
);
    logic [data_width-1:0] rf      [reg_num];
    logic [data_width-1:0] rf_next [reg_num];
    logic [data_width-1:0] rd_a;
    logic [data_width-1:0] rd_b;

    // Out-of-range WA/DA never match any index, so they fall out with no side effect.
    always_comb begin
        for (int i = 0; i < reg_num; i++) begin
            rf_next[i] = rf[i];
            if (bus.WEn && bus.WA == reg_width'(i))
                rf_next[i] = bus.data_in;
            else if (bus.DEC && bus.DA == reg_width'(i) && rf[i] != '0)
                rf_next[i] = rf[i] - data_width'(1);
        end
    end

    // Reads return the post-edge value; an unmatched address reads as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < reg_num; i++) begin
            if (bus.RAA == reg_width'(i)) rd_a = rf_next[i];
            if (bus.RAB == reg_width'(i)) rd_b = rf_next[i];
        end
    end

    always_comb begin
        bus.ZERO = '0;
        for (int i = 0; i < reg_num; i++)
            bus.ZERO[i] = (rf[i] == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < reg_num; i++)
                rf[i] <= '0;
            bus.outA   <= '0;
            bus.outB   <= '0;
            bus.validA <= 1'b0;
            bus.validB <= 1'b0;
        end else begin
            for (int i = 0; i < reg_num; i++)
                rf[i] <= rf_next[i];
            if (bus.REA) bus.outA <= rd_a;
            if (bus.REB) bus.outB <= rd_b;
            bus.validA <= bus.REA;
            bus.validB <= bus.REB;
        end
    end
endmodule

// File: tb/tb_timer_regfile.sv
// Bench for timer_regfile: a 4-entry and a 3-entry instance share one stimulus stream
// and are compared every cycle against an array model, plus literal expectations.
module tb_timer_regfile;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din;
    logic [1:0] wa, da, raa, rab;
    logic       wen, dec, rea, reb;

    timer_regfile_if #(.data_width(8), .reg_width(2), .reg_num(4)) if4 ();
    timer_regfile_if #(.data_width(8), .reg_width(2), .reg_num(3)) if3 ();

    assign if4.data_in = din;  assign if3.data_in = din;
    assign if4.WA  = wa;       assign if3.WA  = wa;
    assign if4.WEn = wen;      assign if3.WEn = wen;
    assign if4.DEC = dec;      assign if3.DEC = dec;
    assign if4.DA  = da;       assign if3.DA  = da;
    assign if4.REA = rea;      assign if3.REA = rea;
    assign if4.REB = reb;      assign if3.REB = reb;
    assign if4.RAA = raa;      assign if3.RAA = raa;
    assign if4.RAB = rab;      assign if3.RAB = rab;

    timer_regfile #(.data_width(8), .reg_width(2), .reg_num(4)) dut4 (
        .CLK(clk), .RST(rst), .bus(if4.slave));
    timer_regfile #(.data_width(8), .reg_width(2), .reg_num(3)) dut3 (
        .CLK(clk), .RST(rst), .bus(if3.slave));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state per instance: index 0 is the 4-entry build, index 1 the 3-entry build.
    int mdl [2][4];
    int ea [2];
    int eb [2];
    bit eva [2];
    bit evb [2];

    function automatic int rn_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] zero_exp(input int k);
        logic [31:0] z;
        z = '0;
        for (int j = 0; j < rn_of(k); j++)
            z[j] = (mdl[k][j] == 0);
        return z;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int rn;
        int nxt [4];
        for (int k = 0; k < 2; k++) begin
            rn = rn_of(k);
            if (rst) begin
                for (int j = 0; j < 4; j++) mdl[k][j] = 0;
                ea[k] = 0; eb[k] = 0; eva[k] = 0; evb[k] = 0;
            end else begin
                nxt = mdl[k];
                if (dec && int'(da) < rn && !(wen && wa == da) && nxt[da] > 0)
                    nxt[da] = nxt[da] - 1;
                if (wen && int'(wa) < rn)
                    nxt[wa] = int'(din);
                eva[k] = rea;
                evb[k] = reb;
                if (rea) ea[k] = (int'(raa) < rn) ? nxt[raa] : 0;
                if (reb) eb[k] = (int'(rab) < rn) ? nxt[rab] : 0;
                mdl[k] = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m4_outA",   if4.outA,   ea[0]);
            check("m4_validA", if4.validA, eva[0]);
            check("m4_outB",   if4.outB,   eb[0]);
            check("m4_validB", if4.validB, evb[0]);
            check("m4_zero",   if4.ZERO,   zero_exp(0));
            check("m3_outA",   if3.outA,   ea[1]);
            check("m3_validA", if3.validA, eva[1]);
            check("m3_outB",   if3.outB,   eb[1]);
            check("m3_validB", if3.validB, evb[1]);
            check("m3_zero",   if3.ZERO,   zero_exp(1));
        end
    end

    task automatic idle();
        rst = 1'b0; din = '0; wa = '0; da = '0; raa = '0; rab = '0;
        wen = 1'b0; dec = 1'b0; rea = 1'b0; reb = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cd_exp [5];
        cd_exp = '{2, 1, 0, 0, 0};

        idle();
        rst = 1'b1;
        step();
        chk_en = 1'b1;

        // Reset overrides a concurrent write and read.
        for (int a = 0; a < 4; a++) begin
            idle(); wen = 1'b1; wa = 2'(a); din = 8'h5A; step();
        end
        check("pre_rst_zero4", if4.ZERO, 4'b0000);
        idle(); rst = 1'b1; wen = 1'b1; wa = 2'd1; din = 8'h77; rea = 1'b1; raa = 2'd2;
        step();
        idle();
        check("rst_outA",   if4.outA,   8'h00);
        check("rst_validA", if4.validA, 1'b0);
        check("rst_zero4",  if4.ZERO,   4'b1111);
        check("rst_zero3",  if3.ZERO,   3'b111);
        for (int a = 0; a < 4; a++) begin
            idle(); rea = 1'b1; raa = 2'(a); step();
            check("rst_readback", if4.outA, 8'h00);
        end

        // Write-first bypass to both ports.
        idle(); wen = 1'b1; wa = 2'd2; din = 8'h3C;
        rea = 1'b1; raa = 2'd2; reb = 1'b1; rab = 2'd2;
        step();
        check("byp_outA",   if4.outA,   8'h3C);
        check("byp_outB",   if4.outB,   8'h3C);
        check("byp_validA", if4.validA, 1'b1);
        check("byp_validB", if4.validB, 1'b1);

        // Countdown from 3 saturates at zero.
        idle(); wen = 1'b1; wa = 2'd1; din = 8'd3; step();
        for (int i = 0; i < 5; i++) begin
            idle(); dec = 1'b1; da = 2'd1; rea = 1'b1; raa = 2'd1; step();
            check("cd_outA",  if4.outA,    cd_exp[i]);
            check("cd_zero1", if4.ZERO[1], (i >= 2) ? 1'b1 : 1'b0);
        end

        // Write beats decrement on the same address; other address still decrements.
        idle(); wen = 1'b1; wa = 2'd0; din = 8'd7; step();
        idle(); wen = 1'b1; wa = 2'd3; din = 8'd5; step();
        idle(); wen = 1'b1; wa = 2'd0; din = 8'd4; dec = 1'b1; da = 2'd0;
        rea = 1'b1; raa = 2'd0;
        step();
        check("coll_outA", if4.outA, 8'd4);
        idle(); wen = 1'b1; wa = 2'd0; din = 8'd9; dec = 1'b1; da = 2'd3;
        rea = 1'b1; raa = 2'd0; reb = 1'b1; rab = 2'd3;
        step();
        check("sep_outA", if4.outA, 8'd9);
        check("sep_outB", if4.outB, 8'd4);
        check("sep3_outB", if3.outB, 8'd0);

        // Hold while REA is low.
        idle(); wen = 1'b1; wa = 2'd3; din = 8'd9; step();
        idle(); rea = 1'b1; raa = 2'd3; step();
        check("hold_rd",     if4.outA,   8'd9);
        check("hold_rd_vld", if4.validA, 1'b1);
        for (int i = 0; i < 2; i++) begin
            idle(); step();
            check("hold_outA",   if4.outA,   8'd9);
            check("hold_validA", if4.validA, 1'b0);
        end

        // Out-of-range write and read on the 3-entry build.
        check("oor_pre_zero3", if3.ZERO, 3'b010);
        idle(); wen = 1'b1; wa = 2'd3; din = 8'hAA; rea = 1'b1; raa = 2'd3; step();
        check("oor3_outA",   if3.outA,   8'd0);
        check("oor3_validA", if3.validA, 1'b1);
        check("oor4_outA",   if4.outA,   8'hAA);
        check("oor3_zero",   if3.ZERO,   3'b010);
        idle(); dec = 1'b1; da = 2'd3; rea = 1'b1; raa = 2'd0; reb = 1'b1; rab = 2'd2; step();
        check("oor3_rd0", if3.outA, 8'd9);
        check("oor3_rd2", if3.outB, 8'h3C);

        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
